// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction fetch unit and
// the load/store unit. One transaction in flight at a time; LSU normally wins,
// a stall counter forces an IFU grant after MAX_STALL back-to-back LSU wins.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transaction; pick a winner and accept it this cycle
// REQ    | latched request presented on mem_*, waiting for mem_req_ready
// RESP   | request taken by memory, waiting for mem_resp_valid
module mem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_STALL = 4,
    parameter int LSU_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_W-1:0]     ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_W-1:0]     lsu_wdata,
    input  logic [DATA_W/8-1:0]   lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_W-1:0]     lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_wen,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(MAX_STALL);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // owner encoding: 0 = IFU, 1 = LSU
    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;

    logic                pick_lsu;
    logic                grant_lsu;
    logic                grant_ifu;

    // Winner selection; grants only exist while idle, so at most one fires.
    always_comb begin
        pick_lsu = 1'b0;
        if (lsu_req_valid) begin
            if (!ifu_req_valid) begin
                pick_lsu = 1'b1;
            end else begin
                pick_lsu = (stall_cnt_q != STALL_MAX) && (LSU_FIRST != 0);
            end
        end
        grant_lsu = (state_q == S_IDLE) && pick_lsu;
        grant_ifu = (state_q == S_IDLE) && ifu_req_valid && !pick_lsu;
    end

    // Next-state, request latching, stall counting and response routing.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        stall_cnt_d      = stall_cnt_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        ifu_rdata_d      = ifu_rdata_q;
        lsu_rdata_d      = lsu_rdata_q;
        ifu_resp_valid_d = 1'b0;
        lsu_resp_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_lsu) begin
                    state_d = S_REQ;
                    owner_d = 1'b1;
                    addr_d  = lsu_addr;
                    wen_d   = lsu_wen;
                    wdata_d = lsu_wdata;
                    wmask_d = lsu_wmask;
                    if (ifu_req_valid && (stall_cnt_q != STALL_MAX)) begin
                        stall_cnt_d = stall_cnt_q + CNT_W'(1);
                    end
                end else if (grant_ifu) begin
                    state_d     = S_REQ;
                    owner_d     = 1'b0;
                    addr_d      = ifu_addr;
                    wen_d       = 1'b0;
                    wdata_d     = '0;
                    wmask_d     = '0;
                    stall_cnt_d = '0;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        lsu_rdata_d      = mem_rdata;
                        lsu_resp_valid_d = 1'b1;
                    end else begin
                        ifu_rdata_d      = mem_rdata;
                        ifu_resp_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset; drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            owner_q          <= 1'b0;
            stall_cnt_q      <= '0;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            ifu_rdata_q      <= '0;
            lsu_rdata_q      <= '0;
            ifu_resp_valid_q <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            stall_cnt_q      <= stall_cnt_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            wdata_q          <= wdata_d;
            wmask_q          <= wmask_d;
            ifu_rdata_q      <= ifu_rdata_d;
            lsu_rdata_q      <= lsu_rdata_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
        end
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign mem_req_valid  = (state_q == S_REQ);
    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wmask      = wmask_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level
// reference model, a simple memory responder with programmable delays, and a
// few literal expectations on grant order and latency.
module tb_mem_arbiter;

    localparam int MAX_STALL = 4;
    localparam int LSU_FIRST = 1;
    localparam logic [63:0] RD_KEY = 64'hA5A5_0000_0000_1234;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        busy;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_STALL(MAX_STALL), .LSU_FIRST(LSU_FIRST)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    req_t ifu_q[$];
    req_t lsu_q[$];
    logic ifu_gnt_s = 1'b0;
    logic lsu_gnt_s = 1'b0;

    int req_delay  = 0;
    int resp_delay = 0;
    logic        acc_s = 1'b0;
    logic [63:0] acc_addr_s = '0;
    logic        resp_pending = 1'b0;

    // transaction log, filled from observed DUT outputs
    int          glog[$];
    int          acc_cyc[$];
    int          mv_cyc[$];
    int          mv_len[$];
    logic [63:0] mv_addr[$];
    logic [63:0] mv_wdata[$];
    logic        mv_wen[$];
    logic [7:0]  mv_mask[$];
    int          rv_cyc[$];
    int          rv_who[$];
    logic [63:0] rv_data[$];
    int          npulse = 0;
    logic        prev_mv = 1'b0;

    // reference model
    bit          m_valid = 0;
    int          m_phase;   // 0 idle, 1 waiting for memory accept, 2 waiting for response
    int          m_owner;   // 0 IFU, 1 LSU
    int          m_stall;
    logic [63:0] m_addr, m_wdata, m_irdata, m_lrdata;
    logic        m_wen, m_irv, m_lrv;
    logic [7:0]  m_mask;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // requester drivers: present the head of each queue, pop it once granted
    initial begin
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ifu_gnt_s && ifu_q.size() > 0) void'(ifu_q.pop_front());
            if (lsu_gnt_s && lsu_q.size() > 0) void'(lsu_q.pop_front());
            ifu_req_valid = (ifu_q.size() > 0);
            if (ifu_q.size() > 0) ifu_addr = ifu_q[0].addr;
            lsu_req_valid = (lsu_q.size() > 0);
            if (lsu_q.size() > 0) begin
                lsu_addr  = lsu_q[0].addr;
                lsu_wen   = lsu_q[0].wen;
                lsu_wdata = lsu_q[0].wdata;
                lsu_wmask = lsu_q[0].wmask;
            end
        end
    end

    // memory responder: ready after req_delay cycles, response resp_delay cycles after accept
    initial begin
        int wait_cnt;
        int resp_cnt;
        logic [63:0] resp_data;
        wait_cnt = 0; resp_cnt = 0; resp_data = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (acc_s) begin
                wait_cnt     = 0;
                resp_cnt     = resp_delay;
                resp_data    = acc_addr_s ^ RD_KEY;
                resp_pending = 1'b1;
            end
            mem_resp_valid = 1'b0;
            if (resp_pending) begin
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = resp_data;
                    resp_pending   = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            if (mem_req_valid) begin
                mem_req_ready = (wait_cnt >= req_delay);
                wait_cnt++;
            end else begin
                mem_req_ready = 1'b0;
                wait_cnt      = 0;
            end
        end
    end

    // compare DUT against the model, log transactions, then advance the model
    initial begin
        forever begin
            logic e_lsu, e_ifu, lsu_pref;
            @(negedge clk);
            cyc++;
            lsu_pref = (LSU_FIRST != 0) && (m_stall < MAX_STALL);
            e_lsu = m_valid && (m_phase == 0) && lsu_req_valid && (!ifu_req_valid || lsu_pref);
            e_ifu = m_valid && (m_phase == 0) && ifu_req_valid && !(lsu_req_valid && lsu_pref);
            if (m_valid) begin
                chk("ifu_req_ready",  ifu_req_ready,  e_ifu);
                chk("lsu_req_ready",  lsu_req_ready,  e_lsu);
                chk("mem_req_valid",  mem_req_valid,  m_phase == 1);
                chk("busy",           busy,           m_phase != 0);
                chk("mem_addr",       mem_addr,       m_addr);
                chk("mem_wen",        mem_wen,        m_wen);
                chk("mem_wdata",      mem_wdata,      m_wdata);
                chk("mem_wmask",      mem_wmask,      m_mask);
                chk("ifu_resp_valid", ifu_resp_valid, m_irv);
                chk("lsu_resp_valid", lsu_resp_valid, m_lrv);
                chk("ifu_rdata",      ifu_rdata,      m_irdata);
                chk("lsu_rdata",      lsu_rdata,      m_lrdata);

                if (ifu_req_ready === 1'b1) begin glog.push_back(0); acc_cyc.push_back(cyc); end
                if (lsu_req_ready === 1'b1) begin glog.push_back(1); acc_cyc.push_back(cyc); end
                if (mem_req_valid === 1'b1) begin
                    if (!prev_mv) begin
                        mv_cyc.push_back(cyc); mv_len.push_back(1);
                        mv_addr.push_back(mem_addr); mv_wdata.push_back(mem_wdata);
                        mv_wen.push_back(mem_wen); mv_mask.push_back(mem_wmask);
                    end else begin
                        mv_len[mv_len.size()-1]++;
                    end
                end
                prev_mv = (mem_req_valid === 1'b1);
                if (ifu_resp_valid === 1'b1) begin
                    npulse++; rv_cyc.push_back(cyc); rv_who.push_back(0); rv_data.push_back(ifu_rdata);
                end
                if (lsu_resp_valid === 1'b1) begin
                    npulse++; rv_cyc.push_back(cyc); rv_who.push_back(1); rv_data.push_back(lsu_rdata);
                end
            end
            ifu_gnt_s  = (ifu_req_ready === 1'b1);
            lsu_gnt_s  = (lsu_req_ready === 1'b1);
            acc_s      = (mem_req_valid === 1'b1) && mem_req_ready;
            acc_addr_s = mem_addr;

            m_irv = 1'b0;
            m_lrv = 1'b0;
            if (rst) begin
                m_valid = 1; m_phase = 0; m_owner = 0; m_stall = 0;
                m_addr = '0; m_wen = 1'b0; m_wdata = '0; m_mask = '0;
                m_irdata = '0; m_lrdata = '0;
            end else if (m_valid) begin
                if (m_phase == 0) begin
                    if (e_lsu) begin
                        m_phase = 1; m_owner = 1;
                        m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_mask = lsu_wmask;
                        if (ifu_req_valid && m_stall < MAX_STALL) m_stall++;
                    end else if (e_ifu) begin
                        m_phase = 1; m_owner = 0; m_stall = 0;
                        m_addr = ifu_addr; m_wen = 1'b0; m_wdata = '0; m_mask = '0;
                    end
                end else if (m_phase == 1) begin
                    if (mem_req_ready) m_phase = 2;
                end else if (mem_resp_valid) begin
                    m_phase = 0;
                    if (m_owner == 1) begin m_lrdata = mem_rdata; m_lrv = 1'b1; end
                    else begin m_irdata = mem_rdata; m_irv = 1'b1; end
                end
            end
        end
    end

    task automatic wait_done(input string nm, input int budget);
        int k;
        k = 0;
        while ((ifu_q.size() > 0 || lsu_q.size() > 0 || busy !== 1'b0 || resp_pending) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            total++; bad++;
            $display("FAIL timeout_%s: still busy after %0d cycles, required idle", nm, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic req_t rd(input logic [63:0] a);
        req_t r;
        r.addr = a; r.wen = 1'b0; r.wdata = '0; r.wmask = '0;
        return r;
    endfunction

    function automatic req_t wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
        req_t r;
        r.addr = a; r.wen = 1'b1; r.wdata = d; r.wmask = m;
        return r;
    endfunction

    initial begin
        int p0;
        int pat[13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // IFU-only read, immediate memory
        ifu_q.push_back(rd(64'h8000_0000));
        wait_done("ifu_read", 40);

        // simultaneous IFU read and LSU write
        lsu_q.push_back(wr(64'h8000_0100, 64'hdead_beef, 8'h0f));
        ifu_q.push_back(rd(64'h8000_0040));
        wait_done("both", 40);

        // both requesters continuously valid
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) lsu_q.push_back(wr(64'h1000 + 64'(8 * i), 64'(i * 17 + 3), 8'(8'h11 << (i % 4))));
            else            lsu_q.push_back(rd(64'h1000 + 64'(8 * i)));
        end
        for (int i = 0; i < 3; i++) ifu_q.push_back(rd(64'h8000_1000 + 64'(4 * i)));
        wait_done("stall", 200);

        // memory holds off request acceptance for 5 cycles
        req_delay = 5;
        lsu_q.push_back(wr(64'h2000, 64'h0123_4567_89ab_cdef, 8'hf0));
        wait_done("req_hold", 60);
        req_delay = 0;

        // response delayed by 10 cycles
        resp_delay = 10;
        ifu_q.push_back(rd(64'h8000_2000));
        wait_done("resp_delay", 60);

        // reset during RESP, stale response arrives afterwards
        resp_delay = 2;
        p0 = npulse;
        ifu_q.push_back(rd(64'h8000_3000));
        begin
            int k;
            k = 0;
            while (!(mem_req_valid === 1'b1 && mem_req_ready === 1'b1) && k < 30) begin
                @(negedge clk);
                k++;
            end
            if (k >= 30) begin
                total++; bad++;
                $display("FAIL timeout_reset_accept: no memory accept after 30 cycles, required one");
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        resp_delay = 0;
        chk("rst_no_pulse", 64'(npulse - p0), 64'd0);
        chk("rst_ifu_rdata", ifu_rdata, 64'd0);
        chk("rst_lsu_rdata", lsu_rdata, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // literal expectations on the logged transactions
        if (glog.size() >= 19 && mv_cyc.size() >= 19 && rv_cyc.size() >= 18) begin
            chk("t1_owner", 64'(glog[0]), 64'd0);
            chk("t1_memv_lat", 64'(mv_cyc[0] - acc_cyc[0]), 64'd1);
            chk("t1_memaddr", mv_addr[0], 64'h8000_0000);
            chk("t1_resp_lat", 64'(rv_cyc[0] - acc_cyc[0]), 64'd3);
            chk("t1_resp_who", 64'(rv_who[0]), 64'd0);
            chk("t1_rdata", rv_data[0], 64'hA5A5_0000_8000_1234);
            chk("t2_first_lsu", 64'(glog[1]), 64'd1);
            chk("t2_then_ifu", 64'(glog[2]), 64'd0);
            chk("t2_wen", {63'd0, mv_wen[1]}, 64'd1);
            chk("t2_wmask", {56'd0, mv_mask[1]}, 64'h0f);
            chk("t2_wdata", mv_wdata[1], 64'hdead_beef);
            chk("t2_addr", mv_addr[1], 64'h8000_0100);
            chk("t2_lsu_rdata", rv_data[1], 64'hA5A5_0000_8000_1334);
            for (int i = 0; i < 13; i++) chk($sformatf("t3_grant%0d", i), 64'(glog[3 + i]), 64'(pat[i]));
            chk("t3_accept_gap", 64'(acc_cyc[4] - acc_cyc[3]), 64'd3);
            chk("t4_memv_len", 64'(mv_len[16]), 64'd6);
            chk("t5_resp_lat", 64'(rv_cyc[17] - mv_cyc[17]), 64'd12);
            chk("t5_resp_who", 64'(rv_who[17]), 64'd0);
            chk("total_pulses", 64'(npulse), 64'd18);
        end else begin
            total++; bad++;
            $display("FAIL log_size: grants=%0d memreqs=%0d resps=%0d, required at least 19/19/18",
                     glog.size(), mv_cyc.size(), rv_cyc.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
